// File: rtl/phrase_vram_scheduler_pkg.sv
// ============================================================================
// Module      : text_pkg
// Description : Shared types and constants for the phrase-to-VRAM text path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package text_pkg;

    typedef enum logic [1:0] {
        FIELD_NOTE = 2'd0,
        FIELD_OCT  = 2'd1,
        FIELD_VOL  = 2'd2,
        FIELD_INST = 2'd3
    } field_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_XLATE = 3'd3,
        S_WRITE = 3'd4
    } state_e;

    // One 16-bit character cell of a VRAM word.
    typedef struct packed {
        logic       iv;
        logic [6:0] code;
        logic [3:0] fgd;
        logic [3:0] bkg;
    } vram_half_t;

    localparam logic [6:0] CHAR_SHARP = 7'h23;
    localparam logic [6:0] CHAR_ZERO  = 7'h30;

endpackage

`default_nettype wire

// File: rtl/phrase_vram_scheduler_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Round-robin first-set finder, searching upward from last+1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N  = 64,
    parameter int IW = 6
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic          o_found,
    output logic [IW-1:0] o_idx
);

    logic [IW-1:0] w_start;
    logic [IW-1:0] w_cand;

    assign w_start = i_last + IW'(1);

    // N is a power of two, so the IW-bit sum wraps N-1 -> 0 on its own.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int i = 0; i < N; i++) begin
            w_cand = w_start + IW'(i);
            if (!o_found && i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/phrase_vram_scheduler.sv
// ============================================================================
// Module      : phrase_vram_scheduler
// Description : Walks dirty phrase cells and renders their four fields to VRAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module phrase_vram_scheduler
    import text_pkg::*;
#(
    parameter int         N_ROWS     = 16,
    parameter int         N_CH       = 4,
    parameter logic [15:0] VRAM_BASE = 16'd0,
    parameter int         ROW_STRIDE = 40,
    parameter int         CH_STRIDE  = 5,
    parameter logic [3:0] FGD_IDX    = 4'hF,
    parameter logic [3:0] BKG_IDX    = 4'h0,
    localparam int        c_row_w    = $clog2(N_ROWS),
    localparam int        c_ch_w     = $clog2(N_CH),
    localparam int        c_cells    = N_ROWS * N_CH,
    localparam int        c_idx_w    = c_row_w + c_ch_w
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               mark_valid,
    input  logic [c_row_w-1:0] mark_row,
    input  logic [c_ch_w-1:0]  mark_ch,
    input  logic               refresh_all,
    input  logic [c_row_w-1:0] cursor_row,
    input  logic [c_ch_w-1:0]  cursor_ch,
    input  logic [1:0]         cursor_field,
    output logic [c_idx_w-1:0] ph_addr,
    input  logic [15:0]        ph_data,
    output logic [15:0]        pc_phrase,
    output logic [1:0]         pc_sel,
    input  logic [13:0]        pc_codes,
    output logic               vram_req,
    output logic [15:0]        vram_addr,
    output logic [31:0]        vram_wdata,
    input  logic               vram_ready,
    output logic               busy,
    output logic               frame_done
);

    state_e               r_state;
    field_e               r_field;
    logic [c_cells-1:0]   r_dirty;
    logic [c_idx_w-1:0]   r_idx;
    logic [c_idx_w-1:0]   r_last;
    logic [c_idx_w-1:0]   r_ph_addr;
    logic [15:0]          r_phrase;
    logic [1:0]           r_sel;
    logic                 r_req;
    logic [15:0]          r_addr;
    logic                 r_busy;
    logic                 r_frame_done;

    logic [c_cells-1:0]   w_dirty_nxt;
    logic                 w_pick_found;
    logic [c_idx_w-1:0]   w_pick_idx;
    logic                 w_take;
    logic                 w_last_accept;
    logic                 w_active_nxt;
    logic                 w_busy_nxt;
    logic [c_row_w-1:0]   w_row;
    logic [c_ch_w-1:0]    w_ch;
    logic [15:0]          w_wr_addr;
    logic [1:0]           w_field_inc;
    logic                 w_iv;
    vram_half_t           w_lo;
    vram_half_t           w_hi;

    rr_pick #(
        .N  (c_cells),
        .IW (c_idx_w)
    ) u_rr_pick (
        .i_req   (r_dirty),
        .i_last  (r_last),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    assign w_take        = (r_state == S_IDLE) && w_pick_found;
    assign w_last_accept = (r_state == S_WRITE) && vram_ready && (r_field == FIELD_INST);

    // Marks are applied after the service clear so a same-cycle mark re-renders the cell.
    always_comb begin
        w_dirty_nxt = r_dirty;
        if (w_take) begin
            w_dirty_nxt[w_pick_idx] = 1'b0;
        end
        if (mark_valid) begin
            w_dirty_nxt[{mark_row, mark_ch}] = 1'b1;
        end
        if (refresh_all) begin
            w_dirty_nxt = '1;
        end
    end

    assign w_active_nxt = w_take || ((r_state != S_IDLE) && !w_last_accept);
    assign w_busy_nxt   = (|w_dirty_nxt) || w_active_nxt;

    assign w_row       = r_idx[c_idx_w-1:c_ch_w];
    assign w_ch        = r_idx[c_ch_w-1:0];
    assign w_wr_addr   = VRAM_BASE + 16'(w_row) * 16'(ROW_STRIDE)
                       + 16'(w_ch) * 16'(CH_STRIDE) + 16'(r_field);
    assign w_field_inc = 2'(r_field) + 2'd1;

    // Write data follows the datapath output directly; the datapath inputs are held
    // for the whole WRITE so the word stays stable while the port is stalled.
    assign w_iv = (r_state == S_WRITE) && ({cursor_row, cursor_ch} == r_idx)
                  && (cursor_field == 2'(r_field));
    assign w_lo = '{iv: w_iv, code: pc_codes[13:7], fgd: FGD_IDX, bkg: BKG_IDX};
    assign w_hi = '{iv: w_iv, code: pc_codes[6:0],  fgd: FGD_IDX, bkg: BKG_IDX};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_field      <= FIELD_NOTE;
            r_dirty      <= '1;
            r_idx        <= '0;
            r_last       <= '1;
            r_ph_addr    <= '0;
            r_phrase     <= '0;
            r_sel        <= '0;
            r_req        <= 1'b0;
            r_addr       <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_dirty      <= w_dirty_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= r_busy && !w_busy_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_idx     <= w_pick_idx;
                        r_last    <= w_pick_idx;
                        r_ph_addr <= w_pick_idx;
                        r_state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_phrase <= ph_data;
                    r_field  <= FIELD_NOTE;
                    r_sel    <= 2'(FIELD_NOTE);
                    r_state  <= S_XLATE;
                end
                S_XLATE: begin
                    r_req   <= 1'b1;
                    r_addr  <= w_wr_addr;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    if (vram_ready) begin
                        r_req <= 1'b0;
                        if (r_field == FIELD_INST) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_field <= field_e'(w_field_inc);
                            r_sel   <= w_field_inc;
                            r_state <= S_XLATE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ph_addr    = r_ph_addr;
    assign pc_phrase  = r_phrase;
    assign pc_sel     = r_sel;
    assign vram_req   = r_req;
    assign vram_addr  = r_addr;
    assign vram_wdata = (r_state == S_WRITE) ? {w_hi, w_lo} : 32'd0;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire
